fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter controller that drives the 11-bit instruction ROM address for the 3BC processor.
- The ROM image holds three back-to-back programs. The block runs one selected program from Start to halt:
  - applies sequential, relative and absolute branch updates;
  - honours datapath stalls;
  - reports completion and cycle count to the testbench-facing top level.
- Sits between the control decoder and the instruction ROM. The ROM is combinational, so the instruction for InstAddress is available in the same cycle.

Parameters:
- AW, 11, instruction address width (2048-entry ROM)
- PROG1_BASE, 11'd0, first instruction address of program 1
- PROG2_BASE, 11'd512, first instruction address of program 2
- PROG3_BASE, 11'd1024, first instruction address of program 3
- CW, 16, cycle-counter width

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  pulse; launch program chosen by ProgSel
- ProgSel  in  2  1/2/3 select program; 0 is illegal and ignored
- Stall  in  1  hold PC this cycle
- BranchEn  in  1  take branch this cycle
- BranchAbs  in  1  1 = absolute target, 0 = PC-relative
- Target  in  AW  absolute branch address
- Offset  in  8  signed two's-complement relative offset
- HaltReq  in  1  decoder saw halt instruction at current PC
- InstAddress  out  AW  ROM address (current PC)
- InstValid  out  1  InstAddress holds a live instruction for the datapath
- Busy  out  1  program running
- Done  out  1  level; set on halt, cleared by next accepted Start
- CycleCount  out  CW  cycles spent in RUN for the last or current program

Behaviour:
- States: IDLE, LOAD, RUN, HALT.
- Reset (async, Reset==0):
  - state=IDLE, PC=0, Done=0, Busy=0, InstValid=0, CycleCount=0.
  - Takes effect mid-program with no completion signalled.
- IDLE or HALT, Start=1 and ProgSel!=0:
  - PC <= matching base; state -> LOAD; Done <= 0; CycleCount <= 0.
  - Start with ProgSel==0 is ignored; state and outputs unchanged.
- LOAD:
  - One settle cycle; InstValid=0, Busy=1.
  - Next state is always RUN.
- RUN:
  - Busy=1, InstValid=1. CycleCount increments every RUN cycle, saturating at all-ones.
  - Priority, highest first: HaltReq > Stall > BranchEn > sequential.
  - HaltReq: state -> HALT, PC unchanged, Done <= 1 the next cycle. The halt cycle is counted.
  - Stall (no HaltReq): PC holds; branch inputs are ignored this cycle. The decoder must re-present the branch after the stall.
  - BranchEn, BranchAbs=1: PC <= Target.
  - BranchEn, BranchAbs=0: PC <= PC + sign-extended Offset, modulo 2^AW (wraps; no error).
  - Otherwise PC <= PC + 1. Wraps 2047 -> 0.
- HALT:
  - Busy=0, InstValid=0, Done=1. PC and CycleCount hold for inspection.
  - Accepts Start as IDLE does.
- Start during LOAD or RUN: ignored; no restart.
- All outputs are registered except InstAddress, which is the PC register itself (zero added latency to ROM).
- Latency: Start accepted at edge N -> first valid fetch (InstValid=1) in cycle N+2.

Decomposition:
- Package fetch_pkg:
  - state enum (IDLE, LOAD, RUN, HALT);
  - AW;
  - the program-base constants;
  - the ProgSel encoding constants.
- Sub-module pc_next (combinational next-PC selector: hold, +1, relative, absolute). It keeps the priority logic and sign-extension arithmetic isolated and unit-testable.

Test Plan:
- Start, ProgSel=2, no branches, HaltReq at PC 515:
  - InstAddress 512, 513, 514, 515; Done=1 one cycle after halt; CycleCount=4.
- Relative branch at PC 1030, Offset=-6:
  - next PC 1024. Same point with Offset=+127: next PC 1157.
- Absolute branch Target=11'd2047, then sequential:
  - PC 2047 -> 0 (wrap). Relative Offset=+1 from 2047 also gives 0.
- Stall asserted 3 cycles together with BranchEn:
  - PC holds 3 cycles, branch not taken.
  - HaltReq with Stall and BranchEn same cycle: halts, PC unchanged.
- Start during RUN ignored:
  - Start with ProgSel=0 in IDLE: no state change.
  - Restart from HALT with ProgSel=3: PC=1024, Done clears, CycleCount resets.
- Reset driven low mid-RUN, asynchronous to Clk:
  - all outputs 0 immediately; no Done pulse.
  - After release, Start resumes normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the 3BC instruction fetch sequencer. It holds the
// address and cycle-counter widths, the program base addresses inside the
// shared ROM image, the ProgSel encoding, the sequencer state type and a
// helper that maps a ProgSel value to its program base.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int AW = 11;   // instruction address width (2048-entry ROM)
    localparam int CW = 16;   // cycle-counter width

    localparam logic [AW-1:0] PROG1_BASE = 11'd0;
    localparam logic [AW-1:0] PROG2_BASE = 11'd512;
    localparam logic [AW-1:0] PROG3_BASE = 11'd1024;

    // ProgSel encoding; PSEL_NONE never launches a program
    localparam logic [1:0] PSEL_NONE  = 2'd0;
    localparam logic [1:0] PSEL_PROG1 = 2'd1;
    localparam logic [1:0] PSEL_PROG2 = 2'd2;
    localparam logic [1:0] PSEL_PROG3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Base address of the program picked by sel. PSEL_NONE is filtered out
    // by the caller; it maps to program 1 only to keep the function total.
    function automatic logic [AW-1:0] prog_base(input logic [1:0] sel);
        logic [AW-1:0] base;
        case (sel)
            PSEL_PROG2: base = PROG2_BASE;
            PSEL_PROG3: base = PROG3_BASE;
            default:    base = PROG1_BASE;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Combinational next-PC selector for the fetch sequencer.
//   pc          in  AW  current program counter
//   hold        in  1   keep the PC (halt or stall); overrides any branch
//   branch_en   in  1   take a branch this cycle
//   branch_abs  in  1   1 = absolute target, 0 = PC-relative
//   target      in  AW  absolute branch address
//   offset      in  8   signed two's-complement relative offset
//   pc_nxt      out AW  selected next PC
// Priority: hold > branch > sequential. All arithmetic wraps modulo 2^AW.
// ---------------------------------------------------------------------------
module pc_next
    import fetch_pkg::*;
(
    input  logic [AW-1:0] pc,
    input  logic          hold,
    input  logic          branch_en,
    input  logic          branch_abs,
    input  logic [AW-1:0] target,
    input  logic [7:0]    offset,
    output logic [AW-1:0] pc_nxt
);

    localparam logic [AW-1:0] PC_INC = 1;

    logic [AW-1:0] offset_ext;

    // Sign-extend so negative offsets wrap correctly in AW-bit arithmetic
    assign offset_ext = {{(AW-8){offset[7]}}, offset};

    always_comb begin
        pc_nxt = pc + PC_INC;
        if (hold) begin
            pc_nxt = pc;
        end else if (branch_en) begin
            pc_nxt = branch_abs ? target : (pc + offset_ext);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Program-counter controller driving the combinational instruction ROM of
// the 3BC processor. Runs one of three programs from Start until halt.
//   Clk          in   1   clock, rising edge
//   Reset        in   1   asynchronous, active-low reset
//   Start        in   1   launch program chosen by ProgSel (IDLE/HALT only)
//   ProgSel      in   2   1/2/3 select program; 0 is ignored
//   Stall        in   1   hold PC this cycle (branch inputs ignored)
//   BranchEn     in   1   take branch this cycle
//   BranchAbs    in   1   1 = absolute target, 0 = PC-relative
//   Target       in   AW  absolute branch address
//   Offset       in   8   signed relative offset
//   HaltReq      in   1   halt instruction at current PC
//   InstAddress  out  AW  ROM address (the PC register itself)
//   InstValid    out  1   InstAddress holds a live instruction (RUN)
//   Busy         out  1   program running (LOAD or RUN)
//   Done         out  1   set on halt, cleared by the next accepted Start
//   CycleCount   out  CW  RUN cycles of the last/current program, saturating
//   DbgState     out  2   current sequencer state, for observation only
// Handshake: there is no backpressure. Start is sampled on a rising edge and
// accepted only in IDLE or HALT with ProgSel != 0; accepted at edge N, the
// first InstValid cycle is N+2 (one LOAD settle cycle in between).
// ---------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [AW-1:0] Target,
    input  logic [7:0]    Offset,
    input  logic          HaltReq,
    output logic [AW-1:0] InstAddress,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] CycleCount,
    output logic [1:0]    DbgState
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_INC = 1;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          inst_valid_q, inst_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic [AW-1:0] pc_run_nxt;

    // In RUN a halt also freezes the PC, so halt and stall share the hold path
    pc_next u_pc_next (
        .pc         (pc_q),
        .hold       (HaltReq | Stall),
        .branch_en  (BranchEn),
        .branch_abs (BranchAbs),
        .target     (Target),
        .offset     (Offset),
        .pc_nxt     (pc_run_nxt)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        done_d        = done_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (Start && (ProgSel != PSEL_NONE)) begin
                    state_d       = ST_LOAD;
                    pc_d          = prog_base(ProgSel);
                    done_d        = 1'b0;
                    cycle_count_d = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // The halt cycle itself is counted
                if (cycle_count_q != CNT_MAX) begin
                    cycle_count_d = cycle_count_q + CNT_INC;
                end
                pc_d = pc_run_nxt;
                if (HaltReq) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
        inst_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            inst_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_valid_q  <= inst_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign InstAddress = pc_q;
    assign InstValid   = inst_valid_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign CycleCount  = cycle_count_q;
    assign DbgState    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed walk through the program launch, branch, stall, halt, restart and
// asynchronous reset scenarios, followed by randomized traffic. Every cycle
// the DUT outputs are compared against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        Stall;
    logic        BranchEn;
    logic        BranchAbs;
    logic [10:0] Target;
    logic [7:0]  Offset;
    logic        HaltReq;
    logic [10:0] InstAddress;
    logic        InstValid;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;
    logic [1:0]  DbgState;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    fetch_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .ProgSel     (ProgSel),
        .Stall       (Stall),
        .BranchEn    (BranchEn),
        .BranchAbs   (BranchAbs),
        .Target      (Target),
        .Offset      (Offset),
        .HaltReq     (HaltReq),
        .InstAddress (InstAddress),
        .InstValid   (InstValid),
        .Busy        (Busy),
        .Done        (Done),
        .CycleCount  (CycleCount),
        .DbgState    (DbgState)
    );

    // ---------------- reference model ----------------
    // Program phase flags: m_loading = settle cycle, m_running = fetching
    bit m_loading, m_running, m_done;
    int m_pc, m_cnt;

    int n_vec  = 0;
    int n_fail = 0;
    logic [10:0] exp_q[$];

    function automatic int base_of(input logic [1:0] sel);
        if (sel == 2'd2) return 512;
        if (sel == 2'd3) return 1024;
        return 0;
    endfunction

    task automatic model_reset();
        m_loading = 0;
        m_running = 0;
        m_done    = 0;
        m_pc      = 0;
        m_cnt     = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else if (m_running) begin
            m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (HaltReq) begin
                m_running = 0;
                m_done    = 1;
            end else if (Stall) begin
                m_pc = m_pc;
            end else if (BranchEn) begin
                if (BranchAbs) m_pc = int'(Target);
                else           m_pc = (m_pc + int'($signed(Offset))) & 2047;
            end else begin
                m_pc = (m_pc + 1) & 2047;
            end
        end else if (m_loading) begin
            m_loading = 0;
            m_running = 1;
        end else if (Start && ProgSel != 2'd0) begin
            m_pc      = base_of(ProgSel);
            m_loading = 1;
            m_done    = 0;
            m_cnt     = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string where);
        check({where, " addr"},  32'(InstAddress), 32'(m_pc));
        check({where, " valid"}, 32'(InstValid),   32'(m_running));
        check({where, " busy"},  32'(Busy),        32'(m_loading | m_running));
        check({where, " done"},  32'(Done),        32'(m_done));
        check({where, " count"}, 32'(CycleCount),  32'(m_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic st, input logic [1:0] sel, input logic stl,
                         input logic br, input logic ab, input logic [10:0] tgt,
                         input logic [7:0] off, input logic hlt);
        Start     = st;
        ProgSel   = sel;
        Stall     = stl;
        BranchEn  = br;
        BranchAbs = ab;
        Target    = tgt;
        Offset    = off;
        HaltReq   = hlt;
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later
    task automatic step(input string where);
        model_edge();
        @(posedge Clk);
        #1;
        check_all(where);
    endtask

    task automatic cyc(input string where, input logic st, input logic [1:0] sel,
                       input logic stl, input logic br, input logic ab,
                       input logic [10:0] tgt, input logic [7:0] off, input logic hlt);
        drive(st, sel, stl, br, ab, tgt, off, hlt);
        step(where);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b0;
        drive(0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        #1;
        model_reset();
        check_all("reset");
        step("reset_hold");
        Reset = 1'b1;

        // Start with ProgSel 0 is ignored
        cyc("sel0", 1, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        check("sel0_busy", 32'(Busy), 32'd0);

        // Program 2, sequential fetch, halt at 515
        cyc("p2_start", 1, 2'd2, 0, 0, 0, 11'd0, 8'd0, 0);
        check("p2_load_addr", 32'(InstAddress), 32'd512);
        check("p2_load_valid", 32'(InstValid), 32'd0);
        exp_q = '{11'd512, 11'd513, 11'd514, 11'd515};
        while (exp_q.size() > 0) begin
            cyc("p2_seq", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
            check("p2_trace", 32'(InstAddress), 32'(exp_q.pop_front()));
        end
        cyc("p2_halt", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 1);
        check("p2_done", 32'(Done), 32'd1);
        check("p2_count", 32'(CycleCount), 32'd4);
        check("p2_pc_hold", 32'(InstAddress), 32'd515);

        // Restart program 3 from HALT; Start during LOAD/RUN is ignored
        cyc("p3_start", 1, 2'd3, 0, 0, 0, 11'd0, 8'd0, 0);
        check("p3_addr", 32'(InstAddress), 32'd1024);
        check("p3_done_clr", 32'(Done), 32'd0);
        check("p3_count_clr", 32'(CycleCount), 32'd0);
        cyc("p3_load_start", 1, 2'd1, 0, 0, 0, 11'd0, 8'd0, 0);
        for (int i = 0; i < 6; i++) cyc("p3_run_start", 1, 2'd1, 0, 0, 0, 11'd0, 8'd0, 0);
        check("p3_at_1030", 32'(InstAddress), 32'd1030);

        // Relative and absolute branches, including wrap at 2047
        cyc("rel_m6", 0, 2'd0, 0, 1, 0, 11'd0, 8'hFA, 0);
        check("rel_m6_pc", 32'(InstAddress), 32'd1024);
        cyc("abs_1030", 0, 2'd0, 0, 1, 1, 11'd1030, 8'd0, 0);
        cyc("rel_p127", 0, 2'd0, 0, 1, 0, 11'd0, 8'h7F, 0);
        check("rel_p127_pc", 32'(InstAddress), 32'd1157);
        cyc("abs_2047", 0, 2'd0, 0, 1, 1, 11'd2047, 8'd0, 0);
        check("abs_2047_pc", 32'(InstAddress), 32'd2047);
        cyc("seq_wrap", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        check("seq_wrap_pc", 32'(InstAddress), 32'd0);
        cyc("abs_2047b", 0, 2'd0, 0, 1, 1, 11'd2047, 8'd0, 0);
        cyc("rel_wrap", 0, 2'd0, 0, 1, 0, 11'd0, 8'h01, 0);
        check("rel_wrap_pc", 32'(InstAddress), 32'd0);

        // Stall beats branch; halt beats both
        for (int i = 0; i < 3; i++) begin
            cyc("stall_br", 0, 2'd0, 1, 1, 1, 11'd100, 8'd0, 0);
            check("stall_pc", 32'(InstAddress), 32'd0);
        end
        cyc("halt_all", 0, 2'd0, 1, 1, 1, 11'd100, 8'd5, 1);
        check("halt_all_pc", 32'(InstAddress), 32'd0);
        check("halt_all_done", 32'(Done), 32'd1);

        // Asynchronous reset in the middle of RUN
        cyc("p1_start", 1, 2'd1, 0, 0, 0, 11'd0, 8'd0, 0);
        cyc("p1_run", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        cyc("p1_run", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        cyc("reset_low", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 1);
        check("reset_no_done", 32'(Done), 32'd0);
        Reset = 1'b1;
        cyc("resume_start", 1, 2'd2, 0, 0, 0, 11'd0, 8'd0, 0);
        cyc("resume_run", 0, 2'd0, 0, 0, 0, 11'd0, 8'd0, 0);
        check("resume_pc", 32'(InstAddress), 32'd512);
        check("resume_valid", 32'(InstValid), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)),
                  11'($urandom_range(0, 2047)),
                  8'($urandom_range(0, 255)),
                  $urandom_range(0, 19) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
